mux_scan_capture: RTL and testbench

Sequencer that sits directly upstream and downstream of the 8:1 multiplexer tree (`mux8_1`). It drives the mux's 3-bit select, waits a programmable settle time per channel, and samples the mux output. This converts the eight mux inputs into one registered 8-bit word with a start/done handshake. Used wherever the design needs a snapshot of all eight channels through a single serial mux path.

---
 rtl/mux_scan_capture_if.sv | 32 +++
 rtl/mux_scan_capture.sv | 123 ++++++++++++
 tb/tb_mux_scan_capture.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_scan_capture_if.sv
// Bundle between the scan sequencer and its requester/mux path.
// The requester side issues start/abort and supplies the mux output.
// The sequencer side returns the mux select, the busy/done status and the captured word.
interface mux_scan_capture_if;
    logic       start;
    logic       abort;
    logic       inY;
    logic [2:0] outS;
    logic       busy;
    logic       done;
    logic [7:0] data;

    modport master (
        output start,
        output abort,
        output inY,
        input  outS,
        input  busy,
        input  done,
        input  data
    );

    modport slave (
        input  start,
        input  abort,
        input  inY,
        output outS,
        output busy,
        output done,
        output data
    );
endinterface

// File: rtl/mux_scan_capture.sv
// Scan sequencer for an 8:1 mux tree.
// It steps the select through channels 0..7 and holds each one for HOLD_CYCLES cycles.
// It samples the mux output on the last edge of each hold window and publishes the
// eight samples as one registered word, with a one-cycle done pulse.
// An abort discards the partial scan and leaves the published word untouched.
module mux_scan_capture #(
    parameter int HOLD_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    mux_scan_capture_if.slave  bus
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Reload value is deliberately truncated to the counter width.
    localparam logic [7:0] HOLD_RELOAD = 8'(HOLD_CYCLES - 32'sd1);
    localparam logic [2:0] LAST_CH     = 3'd7;

    state_t     stateR;
    state_t     stateNextS;
    logic [2:0] chR;
    logic [2:0] chNextS;
    logic [7:0] hcR;
    logic [7:0] hcNextS;
    logic [7:0] shR;
    logic [7:0] shNextS;
    logic [7:0] dataR;
    logic [7:0] dataNextS;
    logic       busyR;
    logic       busyNextS;
    logic       doneR;
    logic       doneNextS;

    // Next-state and next-output decode; every register holds unless a rule below changes it.
    always_comb begin
        stateNextS = stateR;
        chNextS    = chR;
        hcNextS    = hcR;
        shNextS    = shR;
        dataNextS  = dataR;
        busyNextS  = busyR;
        doneNextS  = 1'b0;

        case (stateR)
            IDLE: begin
                if (bus.start) begin
                    stateNextS = SCAN;
                    chNextS    = 3'd0;
                    hcNextS    = HOLD_RELOAD;
                    shNextS    = 8'h00;
                    busyNextS  = 1'b1;
                end else begin
                    stateNextS = IDLE;
                    chNextS    = 3'd0;
                    busyNextS  = 1'b0;
                end
            end

            SCAN: begin
                if (bus.abort) begin
                    // Abort wins even over the final sample; the partial result is dropped.
                    stateNextS = IDLE;
                    chNextS    = 3'd0;
                    hcNextS    = 8'h00;
                    busyNextS  = 1'b0;
                end else if (hcR != 8'h00) begin
                    hcNextS = hcR - 8'd1;
                end else begin
                    shNextS[chR] = bus.inY;
                    if (chR != LAST_CH) begin
                        chNextS = chR + 3'd1;
                        hcNextS = HOLD_RELOAD;
                    end else begin
                        // The last sample goes straight into the published word.
                        stateNextS = IDLE;
                        dataNextS  = shNextS;
                        doneNextS  = 1'b1;
                        busyNextS  = 1'b0;
                        chNextS    = 3'd0;
                    end
                end
            end

            default: begin
                stateNextS = IDLE;
                chNextS    = 3'd0;
                hcNextS    = 8'h00;
                busyNextS  = 1'b0;
            end
        endcase
    end

    // State and output registers; the asynchronous reset also clears the published word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateR <= IDLE;
            chR    <= 3'd0;
            hcR    <= 8'h00;
            shR    <= 8'h00;
            dataR  <= 8'h00;
            busyR  <= 1'b0;
            doneR  <= 1'b0;
        end else begin
            stateR <= stateNextS;
            chR    <= chNextS;
            hcR    <= hcNextS;
            shR    <= shNextS;
            dataR  <= dataNextS;
            busyR  <= busyNextS;
            doneR  <= doneNextS;
        end
    end

    assign bus.outS = chR;
    assign bus.busy = busyR;
    assign bus.done = doneR;
    assign bus.data = dataR;

endmodule

// File: tb/tb_mux_scan_capture.sv
// Bench for mux_scan_capture.
// It runs three instances with hold times 1, 2 and 3, each fed by a behavioural 8:1 mux.
// A scan-level model predicts busy, select, done and data.
// A compare process checks every instance against that model on every falling edge.
// Directed checks with hand-computed literals pin the model at key cycles.
module tb_mux_scan_capture;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] startV = 3'b000;
    logic [2:0] abortV = 3'b000;
    logic [7:0] muxIn [3];

    logic [2:0] outSW [3];
    logic       busyW [3];
    logic       doneW [3];
    logic [7:0] dataW [3];

    int tests  = 0;
    int failed = 0;

    // Scan-level model state.
    int         cyc = 0;
    logic       mActive [3];
    int         mStart  [3];
    int         doneAt  [3];
    logic [7:0] mData   [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gInst
        mux_scan_capture_if ifc ();

        mux_scan_capture #(.HOLD_CYCLES(g + 1)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (ifc.slave)
        );

        assign ifc.start = startV[g];
        assign ifc.abort = abortV[g];
        assign ifc.inY   = muxIn[g][ifc.outS];
        assign outSW[g]  = ifc.outS;
        assign busyW[g]  = ifc.busy;
        assign doneW[g]  = ifc.done;
        assign dataW[g]  = ifc.data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            failed = failed + 1;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scan model: a scan of instance i (hold H=i+1) lasts 8H edges after the start edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                mActive[i] <= 1'b0;
                mStart[i]  <= 0;
                doneAt[i]  <= -100;
                mData[i]   <= 8'h00;
            end
        end else begin
            cyc <= cyc + 1;
            for (int i = 0; i < 3; i++) begin
                if (mActive[i]) begin
                    if (abortV[i]) begin
                        mActive[i] <= 1'b0;
                    end else if (cyc - mStart[i] == 8 * (i + 1)) begin
                        mActive[i] <= 1'b0;
                        mData[i]   <= muxIn[i];
                        doneAt[i]  <= cyc;
                    end
                end else if (startV[i]) begin
                    mActive[i] <= 1'b1;
                    mStart[i]  <= cyc;
                end
            end
        end
    end

    // Compare every instance against the model on every falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            check($sformatf("cmp%0d busy", i), 32'(busyW[i]), 32'(mActive[i]));
            check($sformatf("cmp%0d outS", i), 32'(outSW[i]),
                  mActive[i] ? 32'((cyc - 1 - mStart[i]) / (i + 1)) : 32'd0);
            check($sformatf("cmp%0d done", i), 32'(doneW[i]), 32'(doneAt[i] == cyc - 1));
            check($sformatf("cmp%0d data", i), 32'(dataW[i]), 32'(mData[i]));
        end
    end

    initial begin
        muxIn[0] = 8'h00;
        muxIn[1] = 8'h00;
        muxIn[2] = 8'h00;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", 32'(busyW[0]), 32'd0);
        check("rst done", 32'(doneW[0]), 32'd0);
        check("rst outS", 32'(outSW[0]), 32'd0);
        check("rst data", 32'(dataW[0]), 32'h00);
        rst_n = 1'b1;
        tick();

        // H=1, inputs A5.
        muxIn[0] = 8'hA5;
        startV[0] = 1'b1;
        tick();
        startV[0] = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check("t1 outS", 32'(outSW[0]), 32'(c - 1));
            check("t1 busy", 32'(busyW[0]), 32'd1);
            tick();
        end
        check("t1 done", 32'(doneW[0]), 32'd1);
        check("t1 data", 32'(dataW[0]), 32'hA5);
        check("t1 busy off", 32'(busyW[0]), 32'd0);
        tick();
        check("t1 done pulse", 32'(doneW[0]), 32'd0);

        // H=3, inputs 3C.
        muxIn[2] = 8'h3C;
        startV[2] = 1'b1;
        tick();
        startV[2] = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            check("t2 outS", 32'(outSW[2]), 32'((c - 1) / 3));
            tick();
        end
        check("t2 done", 32'(doneW[2]), 32'd1);
        check("t2 data", 32'(dataW[2]), 32'h3C);
        tick();

        // H=1: start mid-scan is ignored; start in the done cycle chains the next scan.
        startV[0] = 1'b1;
        tick();
        startV[0] = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            startV[0] = (c == 4);
            check("t3 no early done", 32'(doneW[0]), 32'd0);
            tick();
        end
        startV[0] = 1'b0;
        check("t3 done", 32'(doneW[0]), 32'd1);
        check("t3 data", 32'(dataW[0]), 32'hA5);
        muxIn[0] = 8'h5A;
        startV[0] = 1'b1;
        tick();
        startV[0] = 1'b0;
        check("t3 chain outS", 32'(outSW[0]), 32'd0);
        check("t3 chain busy", 32'(busyW[0]), 32'd1);
        check("t3 chain done", 32'(doneW[0]), 32'd0);
        repeat (8) tick();
        check("t3 chain done2", 32'(doneW[0]), 32'd1);
        check("t3 chain data", 32'(dataW[0]), 32'h5A);
        tick();

        // H=2: load A5, then abort at cycle 6, then scan FF.
        muxIn[1] = 8'hA5;
        startV[1] = 1'b1;
        tick();
        startV[1] = 1'b0;
        repeat (16) tick();
        check("t4 pre done", 32'(doneW[1]), 32'd1);
        check("t4 pre data", 32'(dataW[1]), 32'hA5);
        tick();
        startV[1] = 1'b1;
        tick();
        startV[1] = 1'b0;
        repeat (5) tick();
        check("t4 outS c6", 32'(outSW[1]), 32'd2);
        abortV[1] = 1'b1;
        tick();
        abortV[1] = 1'b0;
        check("t4 abort busy", 32'(busyW[1]), 32'd0);
        check("t4 abort outS", 32'(outSW[1]), 32'd0);
        for (int c = 0; c < 12; c++) begin
            check("t4 abort no done", 32'(doneW[1]), 32'd0);
            check("t4 abort data", 32'(dataW[1]), 32'hA5);
            tick();
        end
        muxIn[1] = 8'hFF;
        startV[1] = 1'b1;
        tick();
        startV[1] = 1'b0;
        repeat (16) tick();
        check("t4 ff done", 32'(doneW[1]), 32'd1);
        check("t4 ff data", 32'(dataW[1]), 32'hFF);
        tick();

        // H=1: abort on the final sample edge.
        startV[0] = 1'b1;
        tick();
        startV[0] = 1'b0;
        repeat (7) tick();
        check("t5 outS c8", 32'(outSW[0]), 32'd7);
        abortV[0] = 1'b1;
        tick();
        abortV[0] = 1'b0;
        check("t5 no done", 32'(doneW[0]), 32'd0);
        check("t5 data kept", 32'(dataW[0]), 32'h5A);
        check("t5 busy", 32'(busyW[0]), 32'd0);
        tick();
        check("t5 no late done", 32'(doneW[0]), 32'd0);

        // Asynchronous reset mid-scan, between edges.
        startV[0] = 1'b1;
        tick();
        startV[0] = 1'b0;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6 busy", 32'(busyW[0]), 32'd0);
        check("t6 done", 32'(doneW[0]), 32'd0);
        check("t6 outS", 32'(outSW[0]), 32'd0);
        check("t6 data0", 32'(dataW[0]), 32'h00);
        check("t6 data1", 32'(dataW[1]), 32'h00);
        check("t6 data2", 32'(dataW[2]), 32'h00);
        tick();
        rst_n = 1'b1;
        tick();
        muxIn[0] = 8'hC3;
        startV[0] = 1'b1;
        tick();
        startV[0] = 1'b0;
        repeat (8) tick();
        check("t6 fresh done", 32'(doneW[0]), 32'd1);
        check("t6 fresh data", 32'(dataW[0]), 32'hC3);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
